// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: processor-side write/status bus of the UART transmitter.
interface uart_tx_fifo_if #(
    parameter int FIFO_DEPTH = 4
);
    logic                          wr_en;
    logic [7:0]                    wr_data;
    logic                          fifo_full;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          busy;
    logic                          overflow;

    modport master (
        output wr_en, wr_data,
        input  fifo_full, fifo_count, busy, overflow
    );

    modport slave (
        input  wr_en, wr_data,
        output fifo_full, fifo_count, busy, overflow
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered 8N1 UART transmitter, LSB first, with polled status.
module uart_tx_fifo #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD        = 115200,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    uart_tx_fifo_if.slave    bus,
    output logic             TXD
);
    localparam int CPB = CLK_FREQ_HZ / BAUD;
    localparam int BW  = $clog2(CPB + 1);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam logic [BW-1:0] LAST = BW'(CPB - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state, state_d;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic [BW-1:0]   baud, baud_d;
    logic [2:0]      bit_idx, bit_idx_d;
    logic [7:0]      shift, shift_d;
    logic            txd_d, pop, push, bit_end;

    assign bit_end        = baud == LAST;
    assign push           = bus.wr_en && count != CW'(FIFO_DEPTH);
    assign bus.fifo_full  = count == CW'(FIFO_DEPTH);
    assign bus.fifo_count = count;
    assign bus.busy       = state != IDLE || count != '0;

    always_comb begin
        state_d   = state;
        pop       = 1'b0;
        txd_d     = TXD;
        shift_d   = shift;
        bit_idx_d = bit_idx;
        baud_d    = (state == IDLE || bit_end) ? '0 : baud + 1'b1;
        unique case (state)
            IDLE: begin
                txd_d = 1'b1;
                if (count != '0) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr];
                    txd_d   = 1'b0;
                    state_d = START;
                end
            end
            START: if (bit_end) begin
                txd_d     = shift[0];
                bit_idx_d = '0;
                state_d   = DATA;
            end
            DATA: if (bit_end) begin
                shift_d   = {1'b0, shift[7:1]};
                txd_d     = bit_idx == 3'd7 ? 1'b1 : shift[1];
                bit_idx_d = bit_idx + 1'b1;
                state_d   = bit_idx == 3'd7 ? STOP : DATA;
            end
            STOP: begin
                txd_d = 1'b1;
                // back-to-back frames: next start bit follows the stop bit with no idle gap
                if (bit_end) begin
                    if (count != '0) begin
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr];
                        txd_d   = 1'b0;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= IDLE;
            TXD          <= 1'b1;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            baud         <= '0;
            bit_idx      <= '0;
            shift        <= '0;
            bus.overflow <= 1'b0;
        end else begin
            state   <= state_d;
            TXD     <= txd_d;
            baud    <= baud_d;
            bit_idx <= bit_idx_d;
            shift   <= shift_d;
            wr_ptr  <= wr_ptr + AW'(push);
            rd_ptr  <= rd_ptr + AW'(pop);
            count   <= count + CW'(push) - CW'(pop);
            if (bus.wr_en && !push)
                bus.overflow <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (push)
            mem[wr_ptr] <= bus.wr_data;
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed tests against a queue/frame-timing model plus a line decoder.
module tb_uart_tx_fifo;
    localparam int CPB   = 8;
    localparam int DEPTH = 4;
    localparam int FT    = 10 * CPB;

    logic clk = 1'b0;
    logic RESET = 1'b1;
    logic TXD;

    uart_tx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus();

    uart_tx_fifo #(.CLK_FREQ_HZ(8), .BAUD(1), .FIFO_DEPTH(DEPTH)) dut (
        .CLK(clk), .RESET(RESET), .bus(bus), .TXD(TXD)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0, cyc = 0, lows = 0;
    logic [7:0] mq[$];
    logic [7:0] rx[$];
    int starts[$];
    bit armed = 0, m_act = 0, m_ovf = 0, m_pop;
    int m_t = 0, m_n;
    logic [7:0] m_cur = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: a byte queue plus the elapsed time of the frame on the wire.
    always @(posedge clk) begin
        cyc++;
        if (RESET) begin
            mq.delete();
            m_act = 0;
            m_t   = 0;
            m_ovf = 0;
            armed = 1;
        end else if (armed) begin
            m_n   = mq.size();
            m_pop = m_n > 0 && (!m_act || m_t == FT - 1);
            if (bus.wr_en && m_n == DEPTH) m_ovf = 1;
            if (m_pop) begin
                m_cur = mq.pop_front();
                m_t   = 0;
                m_act = 1;
            end else if (m_act) begin
                if (m_t == FT - 1) m_act = 0;
                else m_t++;
            end
            if (bus.wr_en && m_n < DEPTH) mq.push_back(bus.wr_data);
        end
    end

    function automatic logic m_txd();
        int k;
        if (!m_act) return 1'b1;
        k = m_t / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return m_cur[k-1];
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        if (armed) begin
            chk("m_txd", TXD, m_txd());
            chk("m_count", bus.fifo_count, mq.size());
            chk("m_full", bus.fifo_full, mq.size() == DEPTH);
            chk("m_busy", bus.busy, m_act || mq.size() > 0);
            chk("m_ovf", bus.overflow, m_ovf);
            if (TXD === 1'b0) lows++;
        end
    end

    // Line decoder: samples mid-bit, drops any frame that sees RESET.
    initial begin
        logic [7:0] b;
        bit bad;
        forever begin
            @(negedge clk);
            if (armed && !RESET && TXD === 1'b0) begin
                starts.push_back(cyc);
                bad = 0;
                repeat (4) begin @(negedge clk); bad |= RESET; end
                bad |= TXD !== 1'b0;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) begin @(negedge clk); bad |= RESET; end
                    b[i] = TXD;
                end
                repeat (CPB) begin @(negedge clk); bad |= RESET; end
                bad |= TXD !== 1'b1;
                if (!bad) rx.push_back(b);
            end
        end
    end

    function automatic logic [7:0] rxb(input int i);
        return i < rx.size() ? rx[i] : 8'hxx;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [7:0] b);
        bus.wr_en   = 1'b1;
        bus.wr_data = b;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int k = 0;
        while (bus.busy && k < 3000) begin
            tick();
            k++;
        end
        chk(nm, bus.busy, 1'b0);
        repeat (4) tick();
    endtask

    task automatic clear();
        rx.delete();
        starts.delete();
    endtask

    initial begin
        int l0;
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        RESET       = 1'b1;
        repeat (2) tick();
        RESET = 1'b0;
        chk("t1_txd", TXD, 1'b1);
        chk("t1_busy", bus.busy, 1'b0);
        chk("t1_count", bus.fifo_count, 0);
        chk("t1_full", bus.fifo_full, 1'b0);
        chk("t1_ovf", bus.overflow, 1'b0);
        repeat (100) tick();
        chk("t1_idle_lows", lows, 0);

        clear();
        wr(8'h55);
        for (int k = 1; k <= 81; k++) begin
            tick();
            case (k)
                1:  chk("t2_start_first", TXD, 1'b0);
                8:  chk("t2_start_last", TXD, 1'b0);
                9:  chk("t2_bit0", TXD, 1'b1);
                17: chk("t2_bit1", TXD, 1'b0);
                72: chk("t2_bit7", TXD, 1'b0);
                73: chk("t2_stop", TXD, 1'b1);
                80: chk("t2_busy_hi", bus.busy, 1'b1);
                81: chk("t2_busy_lo", bus.busy, 1'b0);
                default: ;
            endcase
        end
        chk("t2_rx_n", rx.size(), 1);
        chk("t2_rx0", rxb(0), 8'h55);

        clear();
        wr(8'hA5);
        wr(8'h3C);
        wait_idle("t3_idle");
        chk("t3_rx_n", rx.size(), 2);
        chk("t3_rx0", rxb(0), 8'hA5);
        chk("t3_rx1", rxb(1), 8'h3C);
        chk("t3_gap", starts.size() > 1 ? starts[1] - starts[0] : -1, 80);

        clear();
        for (int i = 1; i <= 6; i++) begin
            wr(8'(i));
            if (i == 4) chk("t4_full_early", bus.fifo_full, 1'b0);
            if (i == 5) chk("t4_full", bus.fifo_full, 1'b1);
        end
        chk("t4_count", bus.fifo_count, 4);
        chk("t4_ovf", bus.overflow, 1'b1);
        wait_idle("t4_idle");
        chk("t4_rx_n", rx.size(), 5);
        for (int i = 0; i < 5; i++) chk("t4_rx", rxb(i), 8'(i + 1));
        chk("t4_ovf_sticky", bus.overflow, 1'b1);

        clear();
        wr(8'hFF);
        wr(8'h11);
        wr(8'h22);
        chk("t5_queued", bus.fifo_count, 2);
        repeat (33) tick();
        RESET = 1'b1;
        tick();
        chk("t5_txd", TXD, 1'b1);
        chk("t5_count", bus.fifo_count, 0);
        chk("t5_busy", bus.busy, 1'b0);
        chk("t5_ovf", bus.overflow, 1'b0);
        RESET = 1'b0;
        l0 = lows;
        repeat (200) tick();
        chk("t5_no_frames", lows - l0, 0);
        chk("t5_rx_n", rx.size(), 0);

        clear();
        wr(8'h81);
        wr(8'h42);
        repeat (79) tick();
        chk("t6_count_pre", bus.fifo_count, 1);
        wr(8'hE7);
        chk("t6_count_same", bus.fifo_count, 1);
        chk("t6_restart", TXD, 1'b0);
        wait_idle("t6_idle");
        chk("t6_rx_n", rx.size(), 3);
        chk("t6_rx0", rxb(0), 8'h81);
        chk("t6_rx1", rxb(1), 8'h42);
        chk("t6_rx2", rxb(2), 8'hE7);
        chk("t6_gap", starts.size() > 2 ? starts[2] - starts[1] : -1, 80);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, failed %0d", fails);
        $fatal(1);
    end
endmodule
